// File: rtl/uart_rx_core_if.sv
// Signal bundle between the RX line/config side and the uart_rx_core frame engine.
// The master drives the serial line and frame configuration; the slave (the core)
// returns received data and the per-frame status pulses.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, Data_Valid, Par_Err, Stp_Err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, Data_Valid, Par_Err, Stp_Err
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive frame engine: oversamples RX_IN at the captured prescale, takes a
// 3-sample majority vote mid-bit, rejects glitched start bits, shifts data in LSB
// first, checks optional parity and the stop bit, and emits one status pulse per frame.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8
) (
    input logic           clk,
    input logic           reset,
    uart_rx_core_if.slave bus
);
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [5:0]            edge_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [2:0]            samples_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic [5:0] half;
    logic       bit_end;
    logic       vote_edge;
    logic       majority;
    logic       last_data_bit;

    // Only 16 and 32 are honoured; every other encoding runs at 8 clocks per bit.
    function automatic logic [5:0] decode_prescale(input logic [5:0] p);
        case (p)
            6'd16:   return 6'd16;
            6'd32:   return 6'd32;
            default: return 6'd8;
        endcase
    endfunction

    assign half          = {1'b0, prescale_q[5:1]};
    assign bit_end       = (edge_cnt_q == prescale_q - 6'd1);
    assign vote_edge     = (edge_cnt_q == half + 6'd2);
    assign majority      = (samples_q[0] & samples_q[1]) |
                           (samples_q[0] & samples_q[2]) |
                           (samples_q[1] & samples_q[2]);
    assign last_data_bit = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; a start bit voted high is a glitch and aborts the frame.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.RX_IN) state_d = START;
            START: begin
                if (vote_edge && majority) state_d = IDLE;
                else if (bit_end)          state_d = DATA;
            end
            DATA:    if (bit_end && last_data_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: config capture, edge/bit counters, voting, shifting, error flags, outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: shift_q and samples_q carry no reset; they are always written
            // before being read within a frame, so resetting them buys nothing.
            prescale_q     <= 6'd8;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            par_err_q      <= 1'b0;
            stp_err_q      <= 1'b0;
            bus.P_DATA     <= '0;
            bus.Data_Valid <= 1'b0;
            bus.Par_Err    <= 1'b0;
            bus.Stp_Err    <= 1'b0;
        end else begin
            bus.Data_Valid <= 1'b0;
            bus.Par_Err    <= 1'b0;
            bus.Stp_Err    <= 1'b0;

            if (state_q == IDLE) begin
                edge_cnt_q <= '0;
                bit_cnt_q  <= '0;
                // The cycle that sees the falling edge is edge 0 of the start bit.
                if (!bus.RX_IN) begin
                    edge_cnt_q <= 6'd1;
                    prescale_q <= decode_prescale(bus.Prescale);
                    par_en_q   <= bus.PAR_EN;
                    par_typ_q  <= bus.PAR_TYP;
                    par_err_q  <= 1'b0;
                    stp_err_q  <= 1'b0;
                end
            end else begin
                edge_cnt_q <= bit_end ? 6'd0 : edge_cnt_q + 6'd1;

                if (edge_cnt_q == half - 6'd1) samples_q[0] <= bus.RX_IN;
                if (edge_cnt_q == half)        samples_q[1] <= bus.RX_IN;
                if (edge_cnt_q == half + 6'd1) samples_q[2] <= bus.RX_IN;

                if (vote_edge) begin
                    case (state_q)
                        START:   if (majority) edge_cnt_q <= '0;
                        DATA:    shift_q   <= {majority, shift_q[DATA_WIDTH-1:1]};
                        PARITY:  par_err_q <= majority != ((^shift_q) ^ par_typ_q);
                        STOP:    stp_err_q <= ~majority;
                        default: ;
                    endcase
                end

                if (bit_end && state_q == DATA)
                    bit_cnt_q <= last_data_bit ? '0 : bit_cnt_q + 1'b1;

                // Frame completion: exactly one kind of pulse, on the cycle after the stop bit.
                if (bit_end && state_q == STOP) begin
                    if (par_err_q || stp_err_q) begin
                        bus.Par_Err <= par_err_q;
                        bus.Stp_Err <= stp_err_q;
                    end else begin
                        bus.P_DATA     <= shift_q;
                        bus.Data_Valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core: drives whole frames bit by bit, logs every
// output pulse with its cycle number, and compares against hand-computed timing/data.
module tb_uart_rx_core;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    uart_rx_core_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_core #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Free-running cycle index, used to timestamp pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log: cycle, kind {Stp_Err, Par_Err, Data_Valid}, and P_DATA at that cycle.
    int         ev_cyc[$];
    logic [2:0] ev_kind[$];
    logic [7:0] ev_data[$];

    always @(negedge clk) begin
        if (bus.Data_Valid || bus.Par_Err || bus.Stp_Err) begin
            ev_cyc.push_back(cyc);
            ev_kind.push_back({bus.Stp_Err, bus.Par_Err, bus.Data_Valid});
            ev_data.push_back(bus.P_DATA);
        end
    end

    function automatic logic frame_bit(input logic [7:0] data, input bit par_en,
                                       input logic par_bit, input logic stop_bit, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return data[idx-1];
        if (par_en && idx == 9) return par_bit;
        return stop_bit;
    endfunction

    task automatic clear_log();
        ev_cyc.delete();
        ev_kind.delete();
        ev_data.delete();
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now (caller is #1 after a posedge); t0 is cycle 0.
    task automatic send_frame(input logic [7:0] data, input int bit_len, input logic par_bit,
                              input logic stop_bit, input logic [5:0] mid_pre, output int t0);
        int nbits;
        nbits = bus.PAR_EN ? 11 : 10;
        t0 = cyc;
        for (int b = 0; b < nbits; b++) begin
            bus.RX_IN = frame_bit(data, bus.PAR_EN, par_bit, stop_bit, b);
            if (b == 1 && mid_pre != 6'd0) bus.Prescale = mid_pre;
            repeat (bit_len) @(posedge clk);
            #1;
        end
        bus.RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Prescale = 6'd8;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.P_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_p_data got=%h want=00", bus.P_DATA); end
        n_checks++; if (bus.Data_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got=%b want=0", bus.Data_Valid); end
        n_checks++; if (bus.Par_Err !== 1'b0) begin n_fail++; $display("FAIL reset_par got=%b want=0", bus.Par_Err); end
        n_checks++; if (bus.Stp_Err !== 1'b0) begin n_fail++; $display("FAIL reset_stp got=%b want=0", bus.Stp_Err); end
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_p8_no_parity();
        int t0;
        clear_log();
        bus.Prescale = 6'd8; bus.PAR_EN = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b1, 6'd0, t0);
        idle(4);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL p8_count got=%0d want=1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_cyc[0] - t0 !== 80) begin n_fail++; $display("FAIL p8_cycle got=%0d want=80", ev_cyc[0] - t0); end
            n_checks++; if (ev_kind[0] !== 3'b001) begin n_fail++; $display("FAIL p8_kind got=%b want=001", ev_kind[0]); end
            n_checks++; if (ev_data[0] !== 8'hA5) begin n_fail++; $display("FAIL p8_data got=%h want=a5", ev_data[0]); end
        end
    endtask

    task automatic test_p16_parity();
        int t0;
        clear_log();
        bus.Prescale = 6'd16; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
        send_frame(8'h3C, 16, 1'b0, 1'b1, 6'd0, t0);
        idle(4);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL par_good_count got=%0d want=1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_cyc[0] - t0 !== 176) begin n_fail++; $display("FAIL par_good_cycle got=%0d want=176", ev_cyc[0] - t0); end
            n_checks++; if (ev_kind[0] !== 3'b001) begin n_fail++; $display("FAIL par_good_kind got=%b want=001", ev_kind[0]); end
            n_checks++; if (ev_data[0] !== 8'h3C) begin n_fail++; $display("FAIL par_good_data got=%h want=3c", ev_data[0]); end
        end
        clear_log();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 6'd0, t0);
        idle(4);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL par_bad_count got=%0d want=1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_cyc[0] - t0 !== 176) begin n_fail++; $display("FAIL par_bad_cycle got=%0d want=176", ev_cyc[0] - t0); end
            n_checks++; if (ev_kind[0] !== 3'b010) begin n_fail++; $display("FAIL par_bad_kind got=%b want=010", ev_kind[0]); end
            n_checks++; if (ev_data[0] !== 8'h3C) begin n_fail++; $display("FAIL par_bad_hold got=%h want=3c", ev_data[0]); end
        end
    endtask

    task automatic test_stop_error();
        int t0;
        clear_log();
        bus.Prescale = 6'd32; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
        // 0x01 has odd weight, so the odd-parity bit is 0 and parity itself is good.
        send_frame(8'h01, 32, 1'b0, 1'b0, 6'd0, t0);
        idle(4);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL stp_count got=%0d want=1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_cyc[0] - t0 !== 352) begin n_fail++; $display("FAIL stp_cycle got=%0d want=352", ev_cyc[0] - t0); end
            n_checks++; if (ev_kind[0] !== 3'b100) begin n_fail++; $display("FAIL stp_kind got=%b want=100", ev_kind[0]); end
            n_checks++; if (ev_data[0] !== 8'h3C) begin n_fail++; $display("FAIL stp_hold got=%h want=3c", ev_data[0]); end
        end
        bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Prescale = 6'd8;
    endtask

    task automatic test_glitch();
        int tg, t0;
        clear_log();
        bus.Prescale = 6'd8;
        tg = cyc;
        bus.RX_IN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.RX_IN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_frame(8'h55, 8, 1'b0, 1'b1, 6'd0, t0);
        idle(4);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL glitch_count got=%0d want=1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_cyc[0] - tg !== 87) begin n_fail++; $display("FAIL glitch_cycle got=%0d want=87", ev_cyc[0] - tg); end
            n_checks++; if (ev_kind[0] !== 3'b001) begin n_fail++; $display("FAIL glitch_kind got=%b want=001", ev_kind[0]); end
            n_checks++; if (ev_data[0] !== 8'h55) begin n_fail++; $display("FAIL glitch_data got=%h want=55", ev_data[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        clear_log();
        bus.Prescale = 6'd8;
        send_frame(8'hFF, 8, 1'b0, 1'b1, 6'd0, t0);
        send_frame(8'h00, 8, 1'b0, 1'b1, 6'd0, t1);
        idle(4);
        n_checks++;
        if (ev_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d want=2", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_cyc[0] - t0 !== 80) begin n_fail++; $display("FAIL b2b_cycle0 got=%0d want=80", ev_cyc[0] - t0); end
            n_checks++; if (ev_data[0] !== 8'hFF) begin n_fail++; $display("FAIL b2b_data0 got=%h want=ff", ev_data[0]); end
            n_checks++; if (ev_cyc[1] - t0 !== 160) begin n_fail++; $display("FAIL b2b_cycle1 got=%0d want=160", ev_cyc[1] - t0); end
            n_checks++; if (ev_kind[1] !== 3'b001) begin n_fail++; $display("FAIL b2b_kind1 got=%b want=001", ev_kind[1]); end
            n_checks++; if (ev_data[1] !== 8'h00) begin n_fail++; $display("FAIL b2b_data1 got=%h want=00", ev_data[1]); end
        end
    endtask

    task automatic test_prescale_illegal();
        int t0;
        clear_log();
        bus.Prescale = 6'd12;
        send_frame(8'h5A, 8, 1'b0, 1'b1, 6'd0, t0);
        idle(4);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL pre12_count got=%0d want=1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_cyc[0] - t0 !== 80) begin n_fail++; $display("FAIL pre12_cycle got=%0d want=80", ev_cyc[0] - t0); end
            n_checks++; if (ev_data[0] !== 8'h5A) begin n_fail++; $display("FAIL pre12_data got=%h want=5a", ev_data[0]); end
        end
    endtask

    task automatic test_prescale_change();
        int t0;
        clear_log();
        bus.Prescale = 6'd16;
        send_frame(8'hC3, 16, 1'b0, 1'b1, 6'd8, t0);
        idle(4);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL prechg_count got=%0d want=1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_cyc[0] - t0 !== 160) begin n_fail++; $display("FAIL prechg_cycle got=%0d want=160", ev_cyc[0] - t0); end
            n_checks++; if (ev_data[0] !== 8'hC3) begin n_fail++; $display("FAIL prechg_data got=%h want=c3", ev_data[0]); end
        end
        bus.Prescale = 6'd8;
    endtask

    task automatic test_reset_midframe();
        int t1;
        clear_log();
        bus.Prescale = 6'd8;
        for (int c = 0; c < 40; c++) begin
            bus.RX_IN = frame_bit(8'h3E, 1'b0, 1'b0, 1'b1, c / 8);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        bus.RX_IN = frame_bit(8'h3E, 1'b0, 1'b0, 1'b1, 5);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.RX_IN = 1'b1;
        n_checks++; if (bus.P_DATA !== 8'h00) begin n_fail++; $display("FAIL rstmid_p_data got=%h want=00", bus.P_DATA); end
        n_checks++; if ({bus.Stp_Err, bus.Par_Err, bus.Data_Valid} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_pulses got=%b want=000", {bus.Stp_Err, bus.Par_Err, bus.Data_Valid});
        end
        idle(60);
        n_checks++; if (ev_cyc.size() !== 0) begin n_fail++; $display("FAIL rstmid_aborted got=%0d want=0", ev_cyc.size()); end
        clear_log();
        send_frame(8'h81, 8, 1'b0, 1'b1, 6'd0, t1);
        idle(4);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL rstmid_count got=%0d want=1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_cyc[0] - t1 !== 80) begin n_fail++; $display("FAIL rstmid_cycle got=%0d want=80", ev_cyc[0] - t1); end
            n_checks++; if (ev_data[0] !== 8'h81) begin n_fail++; $display("FAIL rstmid_data got=%h want=81", ev_data[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_p8_no_parity();
        test_p16_parity();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_prescale_illegal();
        test_prescale_change();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
